// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the round-robin shared FP32 adder.
package fp_arb_pkg;

  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

  // Leading-zero count of a 27-bit extended mantissa (27 when all zero).
  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic found;
    clz27 = 5'd27;
    found = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!found && v[26-i]) begin
        clz27 = 5'(i);
        found = 1'b1;
      end
    end
  endfunction

  // Logical right shift that ORs every shifted-out bit into the LSB.
  function automatic logic [26:0] shr_sticky(input logic [26:0] v, input logic [7:0] n);
    logic [26:0] r;
    logic [26:0] lost;
    if (n >= 8'd27) begin
      shr_sticky = {26'b0, |v};
    end else begin
      r = v >> n;
      lost = v & ((27'd1 << n) - 27'd1);
      shr_sticky = {r[26:1], r[0] | (|lost)};
    end
  endfunction

endpackage

// File: rtl/fp_adder_arbiter_fp__adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// subnormals supported. Inf/NaN operands are not handled.
module fp__adder
  import fp_arb_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  output fp32_t s_o
);

  logic        swap, sub, sgn, rup;
  fp32_t       x, y;
  logic [7:0]  ex, ey, d, sh;
  logic [23:0] mx, my, mf;
  logic [26:0] ys, m;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [8:0]  e, ef;
  logic [24:0] mr;

  // Align smaller operand, add/subtract, normalise (left shift capped so
  // the result can become subnormal), then round with guard/round/sticky.
  always_comb begin
    swap = b_i[30:0] > a_i[30:0];
    x    = swap ? b_i : a_i;
    y    = swap ? a_i : b_i;
    ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx   = {x[30:23] != 8'd0, x[22:0]};
    my   = {y[30:23] != 8'd0, y[22:0]};
    d    = ex - ey;
    ys   = shr_sticky({my, 3'b000}, d);
    sub  = x[31] ^ y[31];
    sum  = sub ? ({1'b0, mx, 3'b000} - {1'b0, ys}) : ({1'b0, mx, 3'b000} + {1'b0, ys});
    lz   = clz27(sum[26:0]);
    sh   = '0;
    if (sum[27]) begin
      m = {sum[27:2], sum[1] | sum[0]};
      e = {1'b0, ex} + 9'd1;
    end else begin
      sh = ({3'b000, lz} > (ex - 8'd1)) ? (ex - 8'd1) : {3'b000, lz};
      m  = sum[26:0] << sh;
      e  = {1'b0, ex} - {1'b0, sh};
    end
    rup = m[2] & (m[1] | m[0] | m[3]);
    mr  = {1'b0, m[26:3]} + {24'b0, rup};
    if (mr[24]) begin
      mf = mr[24:1];
      ef = e + 9'd1;
    end else begin
      mf = mr[23:0];
      ef = e;
    end
    sgn = (sub && (sum == 28'd0)) ? 1'b0 : x[31];
    if (ef >= 9'd255) s_o = {sgn, 8'hFF, 23'b0};
    else              s_o = {sgn, (mf[23] ? ef[7:0] : 8'h00), mf[22:0]};
  end

endmodule

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: first active request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    gidx_o,
  output logic               any_o
);

  // Priority search starting at the pointer position.
  always_comb begin
    grant_o = '0;
    gidx_o  = '0;
    any_o   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_o && req_i[(32'(ptr_i) + k) % NUM_REQ]) begin
        grant_o[(32'(ptr_i) + k) % NUM_REQ] = 1'b1;
        gidx_o = ID_W'((32'(ptr_i) + k) % NUM_REQ);
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Round-robin shared FP32 adder: operand stage S1, result stage S2, ID tag.
module fp_adder_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_sum,
  output logic [ID_W-1:0]         out_id,
  output logic [CNT_W-1:0]        done_cnt
);

  typedef struct packed {
    fp32_t           a;
    fp32_t           b;
    logic [ID_W-1:0] id;
  } fp_op_t;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               s1_full_q, s1_full_d;
  fp_op_t             s1_q, s1_d;
  logic               s2_full_q, s2_full_d;
  fp32_t              sum_q, sum_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic               any_req, s2_load, s1_take, xfer;
  fp32_t              sum;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .gidx_o  (gidx),
    .any_o   (any_req)
  );

  fp__adder u_add (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .s_o (sum)
  );

  assign s2_load   = s1_full_q & (~s2_full_q | out_ready);
  assign s1_take   = ~s1_full_q | s2_load;
  assign xfer      = any_req & s1_take & ~rst;
  assign req_ready = grant & {NUM_REQ{s1_take & ~rst}};
  assign out_valid = s2_full_q;
  assign out_sum   = sum_q;
  assign out_id    = id_q;
  assign done_cnt  = cnt_q;

  // Next-state: pointer advance, S1 refill, S2 drain/load, completion count.
  always_comb begin
    ptr_d     = ptr_q;
    s1_full_d = s1_full_q;
    s1_d      = s1_q;
    s2_full_d = s2_full_q;
    sum_d     = sum_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    if (xfer) ptr_d = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    if (s1_take) begin
      s1_full_d = xfer;
      if (xfer) s1_d = '{a: req_a[32*gidx +: 32], b: req_b[32*gidx +: 32], id: gidx};
    end
    if (s2_load) begin
      s2_full_d = 1'b1;
      sum_d     = sum;
      id_d      = s1_q.id;
    end else if (out_ready) begin
      s2_full_d = 1'b0;
    end
    if (s2_full_q && out_ready) cnt_d = cnt_q + 1'b1;
  end

  // State registers with synchronous reset flushing both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      s1_full_q <= 1'b0;
      s1_q      <= '0;
      s2_full_q <= 1'b0;
      sum_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1_full_q <= s1_full_d;
      s1_q      <= s1_d;
      s2_full_q <= s2_full_d;
      sum_q     <= sum_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
